// File: rtl/leitor_de_sete_segmentos_pkg.sv
// Shared seven-segment constants, invalid code and reader FSM states.
// Pattern bit 6 = segment A ... bit 0 = segment G, active-high.
package pacote_sete_segmentos;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    localparam logic [3:0] BCD_INVALIDO = 4'hF;

    typedef enum logic {
        ESPERA,
        CAPTURA
    } estado_t;

    // Returns {invalid, bcd}
    function automatic logic [4:0] decodifica(input logic [6:0] seg);
        case (seg)
            SEG_0:   return {1'b0, 4'd0};
            SEG_1:   return {1'b0, 4'd1};
            SEG_2:   return {1'b0, 4'd2};
            SEG_3:   return {1'b0, 4'd3};
            SEG_4:   return {1'b0, 4'd4};
            SEG_5:   return {1'b0, 4'd5};
            SEG_6:   return {1'b0, 4'd6};
            SEG_7:   return {1'b0, 4'd7};
            SEG_8:   return {1'b0, 4'd8};
            SEG_9:   return {1'b0, 4'd9};
            default: return {1'b1, BCD_INVALIDO};
        endcase
    endfunction

endpackage

// File: rtl/leitor_de_sete_segmentos_detector_de_estabilidade.sv
// Dwell counter: strobes once when a one-hot sample has been
// stable for ESTAVEL_CICLOS consecutive registered samples.
module detector_de_estabilidade #(
    parameter int unsigned ESTAVEL_CICLOS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] i_amostra,
    output logic        o_aceite,
    output logic [10:0] o_amostra
);

    localparam logic [7:0] ALVO = 8'(ESTAVEL_CICLOS);

    logic [10:0] r_anterior;
    logic [7:0]  r_contador;

    logic       w_igual;
    logic       w_um_quente;
    logic [3:0] w_anodo;
    logic [7:0] w_proximo;

    assign w_anodo = i_amostra[10:7];
    assign w_igual = (i_amostra == r_anterior);

    assign w_proximo = !w_igual              ? 8'd1 :
                       (r_contador == 8'hFF) ? r_contador :
                                               r_contador + 8'd1;

    assign w_um_quente = (w_anodo != 4'd0) &&
                         ((w_anodo & (w_anodo - 4'd1)) == 4'd0);

    // Counter already at ALVO blocks a repeat when saturated at 255
    assign o_aceite  = (w_proximo == ALVO) && (r_contador != ALVO) && w_um_quente;
    assign o_amostra = i_amostra;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_anterior <= '0;
            r_contador <= '0;
        end else begin
            r_anterior <= i_amostra;
            r_contador <= w_proximo;
        end
    end

endmodule

// File: rtl/leitor_de_sete_segmentos.sv
// Reads a multiplexed 4-digit seven-segment display and publishes
// each complete digit 0..3 scan as a 16-bit BCD frame.
module leitor_de_sete_segmentos
    import pacote_sete_segmentos::*;
#(
    parameter int unsigned ESTAVEL_CICLOS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segmentos,
    input  logic [3:0]  anodo,
    output logic [15:0] digitos_bcd,
    output logic        valido,
    output logic        erro
);

    logic [3:0]  r_anodo;
    logic [6:0]  r_segmentos;
    estado_t     r_estado;
    logic [1:0]  r_indice;
    logic [15:0] r_quadro;
    logic        r_erro_quadro;
    logic [15:0] r_digitos;
    logic        r_valido;
    logic        r_erro;

    logic        w_aceite;
    logic [10:0] w_amostra;
    logic [1:0]  w_indice;
    logic [4:0]  w_decod;
    logic [3:0]  w_bcd;
    logic        w_invalido;
    logic [15:0] w_quadro_novo;

    estado_t     w_estado_prox;
    logic [1:0]  w_indice_prox;
    logic [15:0] w_quadro_prox;
    logic        w_erro_quadro_prox;
    logic [15:0] w_digitos_prox;
    logic        w_valido_prox;
    logic        w_erro_prox;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_anodo     <= '0;
            r_segmentos <= '0;
        end else begin
            r_anodo     <= anodo;
            r_segmentos <= segmentos;
        end
    end

    detector_de_estabilidade #(
        .ESTAVEL_CICLOS(ESTAVEL_CICLOS)
    ) u_detector (
        .clk       (clk),
        .rst       (rst),
        .i_amostra ({r_anodo, r_segmentos}),
        .o_aceite  (w_aceite),
        .o_amostra (w_amostra)
    );

    // Accept implies one-hot anodo, so the items never overlap
    always_comb begin
        w_indice = 2'd0;
        unique case (1'b1)
            w_aceite & w_amostra[7]:  w_indice = 2'd0;
            w_aceite & w_amostra[8]:  w_indice = 2'd1;
            w_aceite & w_amostra[9]:  w_indice = 2'd2;
            w_aceite & w_amostra[10]: w_indice = 2'd3;
            default:                  w_indice = 2'd0;
        endcase
    end

    assign w_decod    = decodifica(w_amostra[6:0]);
    assign w_invalido = w_decod[4];
    assign w_bcd      = w_decod[3:0];

    always_comb begin
        w_quadro_novo = r_quadro;
        w_quadro_novo[{w_indice, 2'b00} +: 4] = w_bcd;

        w_estado_prox      = r_estado;
        w_indice_prox      = r_indice;
        w_quadro_prox      = r_quadro;
        w_erro_quadro_prox = r_erro_quadro;
        w_digitos_prox     = r_digitos;
        w_valido_prox      = 1'b0;
        w_erro_prox        = 1'b0;

        if (w_aceite) begin
            unique case (r_estado)
                ESPERA: begin
                    if (w_indice == 2'd0) begin
                        w_quadro_prox      = w_quadro_novo;
                        w_erro_quadro_prox = w_invalido;
                        w_indice_prox      = 2'd1;
                        w_estado_prox      = CAPTURA;
                    end
                end
                CAPTURA: begin
                    if (w_indice == r_indice) begin
                        w_quadro_prox      = w_quadro_novo;
                        w_erro_quadro_prox = r_erro_quadro | w_invalido;
                        if (r_indice == 2'd3) begin
                            w_digitos_prox = w_quadro_novo;
                            w_erro_prox    = r_erro_quadro | w_invalido;
                            w_valido_prox  = 1'b1;
                            w_indice_prox  = 2'd0;
                            w_estado_prox  = ESPERA;
                        end else begin
                            w_indice_prox = r_indice + 2'd1;
                        end
                    end else if (w_indice == 2'd0) begin
                        w_quadro_prox      = w_quadro_novo;
                        w_erro_quadro_prox = w_invalido;
                        w_indice_prox      = 2'd1;
                    end else begin
                        w_indice_prox = 2'd0;
                        w_estado_prox = ESPERA;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado      <= ESPERA;
            r_indice      <= '0;
            r_quadro      <= '0;
            r_erro_quadro <= 1'b0;
            r_digitos     <= '0;
            r_valido      <= 1'b0;
            r_erro        <= 1'b0;
        end else begin
            r_estado      <= w_estado_prox;
            r_indice      <= w_indice_prox;
            r_quadro      <= w_quadro_prox;
            r_erro_quadro <= w_erro_quadro_prox;
            r_digitos     <= w_digitos_prox;
            r_valido      <= w_valido_prox;
            r_erro        <= w_erro_prox;
        end
    end

    assign digitos_bcd = r_digitos;
    assign valido      = r_valido;
    assign erro        = r_erro;

endmodule

// File: tb/tb_leitor_de_sete_segmentos.sv
// Bench for leitor_de_sete_segmentos: directed table, latency and
// reset sequences, then random scans against a dwell-level model.
module tb_leitor_de_sete_segmentos;

    localparam int E = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  segmentos;
    logic [3:0]  anodo;
    logic [15:0] digitos_bcd;
    logic        valido;
    logic        erro;

    always #5 clk = ~clk;

    leitor_de_sete_segmentos #(
        .ESTAVEL_CICLOS(E)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .segmentos   (segmentos),
        .anodo       (anodo),
        .digitos_bcd (digitos_bcd),
        .valido      (valido),
        .erro        (erro)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        err;
    } pub_t;

    typedef struct {
        logic [3:0][3:0] an;
        logic [3:0][6:0] sg;
        logic [3:0][7:0] h;
        int              pub;
        logic [15:0]     bcd;
        logic            err;
    } caso_t;

    pub_t        exp_q[$];
    int          n_aval = 0;
    int          n_falhas = 0;
    int          n_pulsos = 0;
    logic        ult_erro = 1'b0;
    logic [15:0] exp_ultimo = 16'h0;
    logic [10:0] anterior = 11'h0;

    logic [6:0] PADRAO [10] = '{7'b1111110, 7'b0110000, 7'b1101101,
                                7'b1111001, 7'b0110011, 7'b1011011,
                                7'b1011111, 7'b1110000, 7'b1111111,
                                7'b1111011};

    bit          m_captura = 0;
    int          m_prox = 0;
    logic [15:0] m_quadro = 16'h0;
    logic        m_err = 1'b0;

    task automatic chk(input string nome, input logic [15:0] obtido,
                       input logic [15:0] esperado);
        n_aval++;
        if (obtido !== esperado) begin
            n_falhas++;
            $display("FAIL %s: got %h expected %h", nome, obtido, esperado);
        end
    endtask

    // One dwell of a constant input: accepted only if long enough and one-hot
    function automatic void modelo(input logic [3:0] an, input logic [6:0] sg,
                                   input int hold);
        int d = -1;
        int v = 15;
        bit inv;
        if (hold < E) return;
        for (int k = 0; k < 4; k++)
            if (an == 4'(1 << k)) d = k;
        if (d < 0) return;
        for (int k = 0; k < 10; k++)
            if (sg == PADRAO[k]) v = k;
        inv = (v == 15);
        if (m_captura && d == m_prox) begin
            m_quadro[4*d +: 4] = 4'(v);
            m_err = m_err | inv;
            if (d == 3) begin
                exp_q.push_back('{bcd: m_quadro, err: m_err});
                m_captura = 0;
            end else begin
                m_prox++;
            end
        end else if (d == 0) begin
            m_quadro[3:0] = 4'(v);
            m_err = inv;
            m_captura = 1;
            m_prox = 1;
        end else begin
            m_captura = 0;
        end
    endfunction

    task automatic aplica(input logic [3:0] an, input logic [6:0] sg,
                          input int hold);
        if (hold <= 0) return;
        if ({an, sg} == anterior) sg = sg ^ 7'h01;
        modelo(an, sg, hold);
        anterior  = {an, sg};
        anodo     = an;
        segmentos = sg;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_digitos", digitos_bcd, 16'h0000);
        chk("reset_valido", {15'b0, valido}, 16'h0);
        chk("reset_erro", {15'b0, erro}, 16'h0);
        @(posedge clk);
        #1;
        exp_q.delete();
        m_captura  = 0;
        m_prox     = 0;
        exp_ultimo = 16'h0;
        anterior   = 11'h0;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (valido) begin
                pub_t e;
                n_pulsos++;
                ult_erro = erro;
                chk("pulso_esperado", 16'(exp_q.size() > 0), 16'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pub_digitos", digitos_bcd, e.bcd);
                    chk("pub_erro", {15'b0, erro}, {15'b0, e.err});
                    exp_ultimo = e.bcd;
                end
            end else begin
                chk("erro_sem_valido", {15'b0, erro}, 16'h0);
                chk("digitos_retidos", digitos_bcd, exp_ultimo);
            end
        end
    end

    caso_t casos[6];

    initial begin
        int p0;
        int lat;
        logic [3:0] an;
        logic [6:0] sg;

        casos[0] = '{an: {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                     sg: {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011},
                     h: {8'd6, 8'd6, 8'd6, 8'd6}, pub: 1, bcd: 16'h1234, err: 1'b0};
        casos[1] = '{an: {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                     sg: {7'b0110000, 7'b0000001, 7'b1111001, 7'b0110011},
                     h: {8'd6, 8'd6, 8'd6, 8'd6}, pub: 1, bcd: 16'h1F34, err: 1'b1};
        casos[2] = '{an: {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                     sg: {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011},
                     h: {8'd6, 8'd6, 8'd3, 8'd6}, pub: 0, bcd: 16'h1F34, err: 1'b0};
        casos[3] = '{an: {4'b0000, 4'b1000, 4'b0010, 4'b0001},
                     sg: {7'b0000000, 7'b1011111, 7'b1111111, 7'b1111011},
                     h: {8'd0, 8'd6, 8'd6, 8'd6}, pub: 0, bcd: 16'h1F34, err: 1'b0};
        casos[4] = '{an: {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                     sg: {7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011},
                     h: {8'd6, 8'd6, 8'd6, 8'd6}, pub: 1, bcd: 16'h6789, err: 1'b0};
        casos[5] = '{an: {4'b0000, 4'b0000, 4'b0000, 4'b0011},
                     sg: {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111},
                     h: {8'd0, 8'd0, 8'd0, 8'd10}, pub: 0, bcd: 16'h6789, err: 1'b0};

        rst = 1'b1;
        anodo = 4'h0;
        segmentos = 7'h0;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            p0 = n_pulsos;
            for (int j = 0; j < 4; j++)
                aplica(casos[i].an[j], casos[i].sg[j], int'(casos[i].h[j]));
            aplica(4'h0, 7'h0, 3);
            chk($sformatf("caso%0d_pulsos", i), 16'(n_pulsos - p0), 16'(casos[i].pub));
            chk($sformatf("caso%0d_digitos", i), digitos_bcd, casos[i].bcd);
            if (casos[i].pub != 0)
                chk($sformatf("caso%0d_erro", i), {15'b0, ult_erro}, {15'b0, casos[i].err});
        end

        // Latency from first registered sample of digit 3 to valido
        aplica(4'b0001, PADRAO[1], 6);
        aplica(4'b0010, PADRAO[2], 6);
        aplica(4'b0100, PADRAO[3], 6);
        modelo(4'b1000, PADRAO[4], 20);
        anterior  = {4'b1000, PADRAO[4]};
        anodo     = 4'b1000;
        segmentos = PADRAO[4];
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (valido && lat < 0) lat = k;
        end
        chk("latencia", 16'(lat), 16'(E + 1));
        chk("latencia_digitos", digitos_bcd, 16'h4321);
        aplica(4'h0, 7'h0, 3);

        // Reset while digit 2 is stable: frame discarded
        p0 = n_pulsos;
        aplica(4'b0001, PADRAO[5], 6);
        aplica(4'b0010, PADRAO[6], 6);
        aplica(4'b0100, PADRAO[7], 6);
        do_reset();
        aplica(4'b0100, PADRAO[7], 6);
        aplica(4'b1000, PADRAO[8], 6);
        aplica(4'h0, 7'h0, 3);
        chk("reset_sem_pub", 16'(n_pulsos - p0), 16'd0);
        chk("reset_digitos_mantem", digitos_bcd, 16'h0000);

        // Digit 0 one cycle short right after reset
        do_reset();
        p0 = n_pulsos;
        aplica(4'b0001, PADRAO[1], E - 1);
        aplica(4'b0010, PADRAO[2], 6);
        aplica(4'b0100, PADRAO[3], 6);
        aplica(4'b1000, PADRAO[4], 6);
        aplica(4'h0, 7'h0, 3);
        chk("pos_reset_curto", 16'(n_pulsos - p0), 16'd0);

        p0 = n_pulsos;
        aplica(4'b0001, PADRAO[1], E);
        aplica(4'b0010, PADRAO[2], E);
        aplica(4'b0100, PADRAO[3], E);
        aplica(4'b1000, PADRAO[4], E);
        aplica(4'h0, 7'h0, 3);
        chk("pos_reset_exato", 16'(n_pulsos - p0), 16'd1);
        chk("pos_reset_digitos", digitos_bcd, 16'h4321);

        for (int f = 0; f < 60; f++) begin
            for (int d = 0; d < 4; d++) begin
                an = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(1 << d);
                sg = ($urandom_range(0, 11) == 0) ? 7'($urandom)
                                                  : PADRAO[$urandom_range(0, 9)];
                aplica(an, sg, $urandom_range(3, 7));
            end
        end
        aplica(4'h0, 7'h0, 10);
        chk("fila_vazia", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_aval, n_falhas);
        $finish;
    end

endmodule

// File: doc/leitor_de_sete_segmentos.md
LEITOR_DE_SETE_SEGMENTOS -- requirements
Module: leitor_de_sete_segmentos

Interface
REQ-001 Parameter ESTAVEL_CICLOS, default 4, is the number of consecutive identical samples needed to accept a digit; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 segmentos  input  7  segment pattern, bit 6 = A ... bit 0 = G, active-high.
REQ-005 anodo  input  4  digit select, active-high one-hot; bit 0 = least significant display digit.
REQ-006 digitos_bcd  output  16  last published frame; digit n occupies bits [4n+3:4n].
REQ-007 valido  output  1  one-cycle pulse marking a new digitos_bcd value.
REQ-008 erro  output  1  high with valido when any digit of the published frame was an unrecognised pattern.

Function
REQ-009 Inputs shall be registered once before use; all timing below refers to registered samples.
REQ-010 The stability counter shall increment, saturating, when the sample {anodo, segmentos} equals the previous sample, and shall reload to 1 on any change.
REQ-011 A digit shall be accepted exactly once per dwell: when the counter reaches ESTAVEL_CICLOS and anodo is one-hot; no re-accept until the sample changes.
REQ-012 A sample with anodo not one-hot (0000 or multi-hot) shall never be accepted, but still counts as a change.
REQ-013 Decode: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
REQ-014 Any other pattern, including 0000000, shall decode to 4'hF and mark the frame in error.
REQ-015 FSM states: ESPERA and CAPTURA; reset state is ESPERA; the expected index is 0 in ESPERA.
REQ-016 ESPERA: accepting digit 0 stores it, clears the frame error flag, sets the expected index to 1 and enters CAPTURA; accepting any other digit is ignored.
REQ-017 CAPTURA: accepting the expected index n stores it and increments the index; when n = 3, the frame is published and the FSM returns to ESPERA.
REQ-018 CAPTURA, out-of-order accept: an index other than the expected one aborts the frame with no publish; an index 0 restarts the frame as in REQ-016, any other index goes to ESPERA.
REQ-019 Publish: digitos_bcd, erro and valido shall update in the cycle after the accept of digit 3; valido is high for exactly that one cycle.
REQ-020 digitos_bcd shall hold its value between publishes; erro shall be low whenever valido is low.
REQ-021 Latency from the first registered sample of digit 3 to valido shall be ESTAVEL_CICLOS cycles.

Reset
REQ-022 On rst: FSM to ESPERA, stability counter to 0, input register to 0, digitos_bcd = 16'h0000, valido = 0, erro = 0, partial frame discarded.
REQ-023 rst asserted mid-frame shall abort the frame with no publish; the first frame after reset shall start at a fresh digit-0 accept.
REQ-024 Digit 0 must be presented for the full ESTAVEL_CICLOS after rst deasserts before it is accepted.

Structure
REQ-025 Package pacote_sete_segmentos shall hold the ten segment-pattern constants (shared with the BCD-to-segment display driver), the code 4'hF and the FSM state enum.
REQ-026 Stability counting (REQ-010..REQ-012) shall be a sub-module, detector_de_estabilidade, outputting a one-cycle accept strobe plus the accepted sample.
REQ-027 The pattern-to-BCD decode shall be combinational, driven by the package constants.

Verification
REQ-028 Scan 0001/0110011, 0010/1111001, 0100/1101101, 1000/0110000, each held 6 cycles -> one valido pulse, digitos_bcd = 16'h1234, erro = 0.
REQ-029 Same scan with digit 2 segmentos = 0000001 -> digitos_bcd = 16'h1F34, erro = 1 with valido.
REQ-030 Digit 1 held only 3 cycles (ESTAVEL_CICLOS = 4), then 2 and 3 -> no valido; digitos_bcd unchanged.
REQ-031 Order 0,1,3 -> abort with no valido; a following full scan 0..3 of 9,8,7,6 -> 16'h6789.
REQ-032 anodo = 0011 held 10 cycles -> no accept; rst pulse while digit 2 is stable -> outputs return to reset values and there is no publish.
